// File: rtl/afs_dram_bridge.sv
// afs_dram_bridge: turns single-word core read/write requests into DRAM AR/R/AW/W/B transactions, one at a time
// Ports: clk, rst_n (async, active-high); core side req_valid/req_ready/req_write/req_no/req_wdata,
//        rsp_valid/rsp_rdata/rsp_err; DRAM side AR, R, AW, W, B channels.
// Optional: define AFS_BRIDGE_CACHE_EN for a one-entry write-through cache that serves repeat reads.
module afs_dram_bridge #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64,
  parameter int NO_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [NO_W-1:0]   req_no,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [1:0]        R_RESP,
  input  logic [DATA_W-1:0] R_DATA,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP
);
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, RESP} state_t;
  state_t state, state_nxt;
  logic err, hit;
  logic [ADDR_W-1:0] addr;
  assign addr = BASE_ADDR + ADDR_W'({req_no, 3'b000});
  assign req_ready = state == IDLE;
`ifdef AFS_BRIDGE_CACHE_EN
  logic c_valid, hit_q, wr_q;
  logic [NO_W-1:0] c_tag, no_q;
  logic [DATA_W-1:0] c_data;
  assign hit = c_valid && c_tag == req_no && !req_write;
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !req_valid ? IDLE : hit ? RESP : req_write ? WR_AW : RD_AR;
      RD_AR:   state_nxt = AR_READY ? RD_R : RD_AR;
      RD_R:    state_nxt = R_VALID ? RESP : RD_R;
      WR_AW:   state_nxt = AW_READY ? WR_W : WR_AW;
      WR_W:    state_nxt = W_READY ? WR_B : WR_W;
      WR_B:    state_nxt = B_VALID ? RESP : WR_B;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      AR_VALID <= 1'b0;
      AW_VALID <= 1'b0;
      W_VALID <= 1'b0;
      R_READY <= 1'b0;
      B_READY <= 1'b0;
      AR_ADDR <= '0;
      AW_ADDR <= '0;
      W_DATA <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      err <= 1'b0;
`ifdef AFS_BRIDGE_CACHE_EN
      c_valid <= 1'b0;
      c_tag <= '0;
      c_data <= '0;
      hit_q <= 1'b0;
      wr_q <= 1'b0;
      no_q <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef AFS_BRIDGE_CACHE_EN
      // a cache hit already pulsed rsp_valid at acceptance, so its RESP cycle stays quiet
      rsp_valid <= state == RESP && !hit_q;
`else
      rsp_valid <= state == RESP;
`endif
      case (state)
        IDLE: if (req_valid) begin
`ifdef AFS_BRIDGE_CACHE_EN
          hit_q <= hit;
          wr_q <= req_write;
          no_q <= req_no;
          if (hit) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            err <= 1'b0;
            rsp_rdata <= c_data;
          end else
`endif
          if (req_write) begin
            AW_VALID <= 1'b1;
            AW_ADDR <= addr;
            W_DATA <= req_wdata;
          end else begin
            AR_VALID <= 1'b1;
            AR_ADDR <= addr;
          end
        end
        RD_AR: if (AR_READY) begin
          AR_VALID <= 1'b0;
          R_READY <= 1'b1;
        end
        RD_R: if (R_VALID) begin
          R_READY <= 1'b0;
          rsp_rdata <= R_DATA;
          err <= |R_RESP;
        end
        WR_AW: if (AW_READY) begin
          AW_VALID <= 1'b0;
          W_VALID <= 1'b1;
        end
        WR_W: if (W_READY) begin
          W_VALID <= 1'b0;
          B_READY <= 1'b1;
        end
        WR_B: if (B_VALID) begin
          B_READY <= 1'b0;
          err <= |B_RESP;
        end
        RESP: begin
          rsp_err <= err;
`ifdef AFS_BRIDGE_CACHE_EN
          if (!hit_q) begin
            c_valid <= !err;
            c_tag <= no_q;
            c_data <= wr_q ? W_DATA : rsp_rdata;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_afs_dram_bridge.sv
// tb_afs_dram_bridge: randomized transaction-level check of afs_dram_bridge against a memory/latency model
module tb_afs_dram_bridge;
`ifdef AFS_BRIDGE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_no = '0;
  logic [63:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [1:0] R_RESP, B_RESP;
  logic [63:0] R_DATA, W_DATA;

  afs_dram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_no(req_no), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_RESP(R_RESP), .R_DATA(R_DATA),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int d_ar = 0, d_r = 0, d_aw = 0, d_w = 0, d_b = 0;
  logic [1:0] resp_cfg = 2'b00;
  int ar_hs_cnt = 0, aw_hs_cnt = 0;
  logic [16:0] last_ar_addr = '0, last_aw_addr = '0;
  logic [63:0] dmem [int];
  logic [63:0] ref_mem [256];
  logic [63:0] last_rdata = '0;
  bit c_ok = 1'b0;
  logic [7:0] c_no = '0;

  // DRAM slave: decides READY/VALID at each negedge; a handshake happens at the following posedge
  initial begin : slave
    int ar_seen, aw_seen, w_seen, r_wait, b_wait;
    bit r_pend, b_pend, aw_done, p_ar, p_aw, p_w;
    logic [16:0] p_ar_addr, p_aw_addr, r_addr;
    logic [63:0] p_wdata;
    ar_seen = 0; aw_seen = 0; w_seen = 0; r_wait = 0; b_wait = 0;
    r_pend = 0; b_pend = 0; aw_done = 0; p_ar = 0; p_aw = 0; p_w = 0;
    p_ar_addr = '0; p_aw_addr = '0; r_addr = '0; p_wdata = '0;
    AR_READY = 0; R_VALID = 0; R_RESP = 0; R_DATA = 0; AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ar_seen = 0; aw_seen = 0; w_seen = 0; r_pend = 0; b_pend = 0; aw_done = 0; p_ar = 0; p_aw = 0; p_w = 0;
        AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
      end else begin
        if (p_ar) begin
          n_cmp++;
          if (AR_VALID !== 1'b1 || AR_ADDR !== p_ar_addr) begin
            n_bad++;
            $display("FAIL ar_hold: AR_VALID=%b AR_ADDR=%h, required 1 / %h", AR_VALID, AR_ADDR, p_ar_addr);
          end
        end
        if (p_aw) begin
          n_cmp++;
          if (AW_VALID !== 1'b1 || AW_ADDR !== p_aw_addr) begin
            n_bad++;
            $display("FAIL aw_hold: AW_VALID=%b AW_ADDR=%h, required 1 / %h", AW_VALID, AW_ADDR, p_aw_addr);
          end
        end
        if (p_w) begin
          n_cmp++;
          if (W_VALID !== 1'b1 || W_DATA !== p_wdata) begin
            n_bad++;
            $display("FAIL w_hold: W_VALID=%b W_DATA=%h, required 1 / %h", W_VALID, W_DATA, p_wdata);
          end
        end
        p_ar = 0; p_aw = 0; p_w = 0;
        if (r_pend) begin
          if (r_wait > 0) begin
            r_wait--;
            R_VALID = 0;
          end else begin
            R_VALID = 1;
            R_RESP = resp_cfg;
            R_DATA = dmem.exists(int'(r_addr)) ? dmem[int'(r_addr)] : 64'h0;
            if (R_READY === 1'b1) r_pend = 0;
          end
        end else R_VALID = 0;
        if (b_pend) begin
          if (b_wait > 0) begin
            b_wait--;
            B_VALID = 0;
          end else begin
            B_VALID = 1;
            B_RESP = resp_cfg;
            if (B_READY === 1'b1) b_pend = 0;
          end
        end else B_VALID = 0;
        if (W_VALID === 1'b1) begin
          n_cmp++;
          if (!aw_done) begin
            n_bad++;
            $display("FAIL w_early: W_VALID=1 before AW handshake, required 0");
          end
          w_seen++;
          W_READY = w_seen > d_w;
          if (W_READY) begin
            dmem[int'(last_aw_addr)] = W_DATA;
            aw_done = 0; b_pend = 1; b_wait = d_b; w_seen = 0;
          end else begin
            p_w = 1; p_wdata = W_DATA;
          end
        end else W_READY = 0;
        if (AR_VALID === 1'b1) begin
          ar_seen++;
          AR_READY = ar_seen > d_ar;
          if (AR_READY) begin
            ar_hs_cnt++; last_ar_addr = AR_ADDR; r_addr = AR_ADDR; r_pend = 1; r_wait = d_r; ar_seen = 0;
          end else begin
            p_ar = 1; p_ar_addr = AR_ADDR;
          end
        end else AR_READY = 0;
        if (AW_VALID === 1'b1) begin
          aw_seen++;
          AW_READY = aw_seen > d_aw;
          if (AW_READY) begin
            aw_hs_cnt++; last_aw_addr = AW_ADDR; aw_done = 1; aw_seen = 0;
          end else begin
            p_aw = 1; p_aw_addr = AW_ADDR;
          end
        end else AW_READY = 0;
      end
    end
  end

  function automatic void set_delays(input int a, input int r, input int aw, input int w, input int b);
    d_ar = a; d_r = r; d_aw = aw; d_w = w; d_b = b;
  endfunction

  // One request through the bridge, called right after a negedge; expectations come from the model state
  task automatic run_txn(input bit wr, input logic [7:0] no, input logic [63:0] wd, input int hold, input string tag);
    bit hit, got;
    int exp_lat, lat, ar0, aw0, exp_ar, exp_aw;
    logic exp_err;
    logic [63:0] exp_data;
    logic [16:0] exp_addr;
    hit = CACHE && !wr && c_ok && c_no == no;
    exp_lat = hit ? 1 : wr ? 5 + d_aw + d_w + d_b : 4 + d_ar + d_r;
    exp_err = !hit && resp_cfg != 2'b00;
    exp_data = wr ? last_rdata : ref_mem[no];
    exp_addr = 17'h10000 + 17'(no) * 17'd8;
    exp_ar = (!wr && !hit) ? 1 : 0;
    exp_aw = wr ? 1 : 0;
    ar0 = ar_hs_cnt;
    aw0 = aw_hs_cnt;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle_ready: req_ready=%b, required 1", tag, req_ready);
    end
    req_valid = 1; req_write = wr; req_no = no; req_wdata = wd;
    got = 0; lat = 0;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(negedge clk);
      if (c >= hold) req_valid = 0;
      if (rsp_valid === 1'b1) begin
        got = 1; lat = c;
      end else if (c < exp_lat) begin
        n_cmp++;
        if (req_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s busy_ready: cycle %0d req_ready=%b, required 0", tag, c, req_ready);
        end
      end
    end
    req_valid = 0;
    n_cmp++;
    if (!got || lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got=%0d cycles=%0d, required %0d", tag, got, lat, exp_lat);
    end
    n_cmp++;
    if (rsp_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s rsp_err: %b, required %b", tag, rsp_err, exp_err);
    end
    n_cmp++;
    if (rsp_rdata !== exp_data) begin
      n_bad++;
      $display("FAIL %s rsp_rdata: %h, required %h", tag, rsp_rdata, exp_data);
    end
    n_cmp++;
    if (ar_hs_cnt - ar0 != exp_ar || aw_hs_cnt - aw0 != exp_aw) begin
      n_bad++;
      $display("FAIL %s handshakes: ar=%0d aw=%0d, required %0d %0d", tag, ar_hs_cnt - ar0, aw_hs_cnt - aw0, exp_ar, exp_aw);
    end
    if (exp_ar == 1) begin
      n_cmp++;
      if (last_ar_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL %s ar_addr: %h, required %h", tag, last_ar_addr, exp_addr);
      end
    end
    if (wr) begin
      n_cmp++;
      if (last_aw_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL %s aw_addr: %h, required %h", tag, last_aw_addr, exp_addr);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s single_pulse: rsp_valid=%b, required 0", tag, rsp_valid);
    end
    if (wr) ref_mem[no] = wd;
    else last_rdata = exp_data;
    if (!hit) begin
      c_ok = !exp_err;
      c_no = no;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1;
    #1;
    n_cmp++;
    if ({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid, rsp_err, AR_ADDR, AW_ADDR, W_DATA, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: outputs not zero before first clock edge");
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: req_ready=%b during reset, required 1", req_ready);
    end
    rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if ({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid, rsp_err, AR_ADDR, AW_ADDR, W_DATA, rsp_rdata} !== '0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: outputs nonzero or req_ready=%b, required idle", req_ready);
    end
  endtask

  task automatic test_read_basic;
    set_delays(0, 0, 0, 0, 0);
    resp_cfg = 2'b00;
    dmem[int'(17'h10000)] = 64'hDEAD_BEEF_0123_4567;
    ref_mem[0] = 64'hDEAD_BEEF_0123_4567;
    run_txn(0, 8'h00, 64'h0, 1, "read_basic");
  endtask

  task automatic test_write_delayed;
    set_delays(0, 0, 3, 0, 0);
    resp_cfg = 2'b00;
    run_txn(1, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1, "write_ff");
    set_delays(0, 0, 0, 0, 0);
    run_txn(0, 8'hFF, 64'h0, 1, "readback_ff");
  endtask

  task automatic test_error;
    set_delays(0, 1, 0, 0, 0);
    dmem[int'(17'h10018)] = 64'h1357_9BDF_2468_ACE0;
    ref_mem[3] = 64'h1357_9BDF_2468_ACE0;
    resp_cfg = 2'b10;
    run_txn(0, 8'h03, 64'h0, 1, "read_err");
    resp_cfg = 2'b00;
    run_txn(0, 8'h03, 64'h0, 1, "read_ok");
    resp_cfg = 2'b01;
    run_txn(1, 8'h09, 64'hCAFE_F00D_0000_0001, 1, "write_err");
    resp_cfg = 2'b00;
  endtask

  task automatic test_hold;
    set_delays(2, 8, 0, 0, 0);
    resp_cfg = 2'b00;
    run_txn(0, 8'h44, 64'h0, 10, "hold_req");
  endtask

  task automatic test_mid_reset;
    bit found;
    int pulses;
    set_delays(0, 0, 0, 0, 6);
    resp_cfg = 2'b00;
    req_valid = 1; req_write = 1; req_no = 8'h21; req_wdata = 64'h0123_4567_89AB_CDEF;
    found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (B_READY === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL mid_reset_reach: B_READY=%b, required 1 within 20 cycles", B_READY);
    end
    #2 rst_n = 1;
    #1;
    n_cmp++;
    if ({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, rsp_valid, rsp_err, AR_ADDR, AW_ADDR, W_DATA, rsp_rdata} !== '0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_clear: B_READY=%b W_DATA=%h req_ready=%b, required all zero and ready", B_READY, W_DATA, req_ready);
    end
    ref_mem[8'h21] = 64'h0123_4567_89AB_CDEF;
    last_rdata = '0;
    c_ok = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: pulses=%0d req_ready=%b, required 0 / 1", pulses, req_ready);
    end
    set_delays(0, 0, 0, 0, 0);
    run_txn(0, 8'h21, 64'h0, 1, "after_reset_read");
  endtask

`ifdef AFS_BRIDGE_CACHE_EN
  task automatic test_cache;
    set_delays(0, 0, 0, 0, 0);
    resp_cfg = 2'b00;
    run_txn(1, 8'h05, 64'h5555_AAAA_1234_8765, 1, "cache_write5");
    run_txn(0, 8'h05, 64'h0, 1, "cache_hit5");
    run_txn(0, 8'h06, 64'h0, 1, "cache_miss6");
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      resp_cfg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), {$urandom, $urandom}, 1, "random");
    end
    resp_cfg = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset;
    test_read_basic;
    test_write_delayed;
    test_error;
    test_hold;
    test_mid_reset;
`ifdef AFS_BRIDGE_CACHE_EN
    test_cache;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
